// File: rtl/proc_disp_pkg.sv
// Shared types and constants for the processor output display stage.
// Digit slots are 5 bits wide: bit4 set means the digit is blanked.
package proc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HEXLD,
    DONE
  } state_t;

  typedef logic [4:0] slot_t;

  localparam slot_t BLANK = 5'b10000;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/proc_display_seg7_decode.sv
// Digit slot to active-low 7-segment pattern.
// Blank slots turn every segment off.
module seg7_decode
  import proc_disp_pkg::*;
(
  input  slot_t      slot,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!slot[4]) begin
      unique case (slot[3:0])
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/proc_display.sv
// Output display stage: binary word to decimal/hex digits,
// scanned onto a common-anode multiplexed 7-segment display.
module proc_display
  import proc_disp_pkg::*;
#(
  parameter int NBITS    = 16,
  parameter int NDIG     = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] din,
  input  logic             hex,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an,
  output logic             busy,
  output logic [NBITS-1:0] disp_val
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(NBITS) + 1;
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(NDIG + 1);

  state_t             state_q, state_d;
  logic [NBITS-1:0]   bin_q, bin_d;
  logic [NBITS-1:0]   val_q, val_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               shown_q, shown_d;
  logic [NBITS-1:0]   disp_q, disp_d;
  slot_t [NDIG-1:0]   dig_q, dig_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic [BW-1:0]      adj;
  slot_t [NDIG-1:0]   blk;
  slot_t              cur_slot;

  // Shift-add-3 correction applied before each shift
  always_comb begin
    adj = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      else
        adj[4*k +: 4] = bcd_q[4*k +: 4];
    end
  end

  // Leading-zero blanking; digit 0 always shown
  always_comb begin
    logic nz;
    nz  = 1'b0;
    blk = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nz = nz | (bcd_q[4*k +: 4] != 4'd0);
      if (nz || k == 0)
        blk[k] = {1'b0, bcd_q[4*k +: 4]};
      else
        blk[k] = BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    shown_d = shown_q;
    disp_d  = disp_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (din != disp_q || hex != shown_q) begin
          bin_d   = din;
          val_d   = din;
          mode_d  = hex;
          bcd_d   = '0;
          cnt_d   = CW'(NBITS - 1);
          state_d = hex ? HEXLD : CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        if (cnt_q == '0)
          state_d = DONE;
        else
          cnt_d = cnt_q - CW'(1);
      end
      HEXLD: begin
        bcd_d   = BW'(bin_q);
        state_d = DONE;
      end
      DONE: begin
        dig_d   = blk;
        disp_d  = val_q;
        shown_d = mode_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      if (idx_q == IW'(NDIG - 1))
        idx_d = '0;
      else
        idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      shown_q <= 1'b0;
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < NDIG; k++)
        dig_q[k] <= (k == 0) ? 5'd0 : BLANK;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      shown_q <= shown_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    cur_slot = BLANK;
    for (int k = 0; k < NDIG; k++)
      if (idx_q == IW'(k))
        cur_slot = dig_q[k];
  end

  seg7_decode u_dec (
    .slot (cur_slot),
    .seg  (seg)
  );

  assign an       = ~(NDIG'(1) << idx_q);
  assign busy     = (state_q != IDLE);
  assign disp_val = disp_q;

endmodule

// File: doc/proc_display.md
Name: proc_display

Overview:
- Output-side stage downstream of the processor top; consumes the 16-bit `out` word that the processor's print path drives.
- Converts that word to decimal BCD with a sequential shift-add-3 converter, or to hex digits in 1 cycle.
- Drives a time-multiplexed common-anode 7-segment display.
- Re-converts automatically whenever the input word or the display mode changes.

Parameters:
- NBITS, 16: width of displayed word.
- NDIG, 5: number of display digits; must be ≥ decimal digit count of 2^NBITS-1.
- SCAN_DIV, 50000: clock cycles each digit stays enabled.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  NBITS  processor output word (`out`).
- hex  input  1  1 = hexadecimal display, 0 = unsigned decimal.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  output  NDIG  digit enables, active-low, one-hot-low.
- busy  output  1  conversion in progress.
- disp_val  output  NBITS  value currently latched on the display.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` synchronous active-low, sampled on rising clk only.
- Reset values:
  - state=IDLE, busy=0, disp_val=0, shown_hex=0.
  - digit register = {blank…,0}.
  - scan index=0, prescaler=0, an={1…1,0}, seg=7'b1000000 (shows "0").
- States:
  - IDLE: if din!=disp_val or hex!=shown_hex, capture din→bin_sr and hex→mode_r. Go to CONV if mode_r=0, else HEXLD. busy=0 in IDLE.
  - CONV: NBITS iterations. Each cycle, every 4-bit BCD nibble ≥5 gets +3, then {bcd,bin_sr} shifts left 1. Bit counter counts NBITS-1 down to 0; at 0 go to DONE.
  - HEXLD: digit k = bin_sr[4k+3:4k] for k<ceil(NBITS/4); higher digits blank. Next state DONE.
  - DONE: digit register, disp_val and shown_hex update atomically, with leading-zero blanking applied. Return to IDLE.
- busy=1 in CONV, HEXLD and DONE.
- Latency, measured from the edge that samples a changed din to the disp_val update:
  - decimal: NBITS+1 cycles;
  - hex: 2 cycles.
- Leading-zero blanking: digits above the most significant nonzero digit are blank. Digit 0 is never blank, so value 0 shows "0".
- Input changes while busy are ignored. The IDLE compare then retriggers, so the latest stable din is always displayed eventually. The display never shows a partially converted value.
- A hex toggle with unchanged din also retriggers conversion.
- Scan:
  - prescaler counts 0..SCAN_DIV-1 and wraps;
  - on each wrap, the index increments mod NDIG (NDIG-1 wraps to 0);
  - an = ~(1<<index);
  - seg = decode(digit[index]), or 7'h7F if that digit is blank.
- Scan runs independently of conversion; it is never paused by busy.
- Reset mid-conversion: partial result discarded, display returns to "0". If din≠0 after reset, conversion restarts on the first IDLE cycle.

Decomposition:
- Package proc_disp_pkg:
  - state encoding (IDLE, CONV, HEXLD, DONE);
  - BLANK digit code (5-bit digit slots: bit4=blank);
  - 7-segment constants for 0–F and SEG_OFF.
- One combinational sub-module seg7_decode: 5-bit digit slot → 7-bit active-low segments. Instantiated once on the scan path.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, din=0 → seg=7'b1000000, an=5'b11110, busy=0, disp_val=0. Also apply din=5 while rst_n is low → no change until rst_n returns to 1.
2. din=16'd12345, hex=0 → busy high 17 cycles, disp_val=12345 exactly 17 cycles after the sampling edge. With SCAN_DIV=4, digits read 5,4,3,2,1 as an steps 11110→11101→11011→10111→01111→11110.
3. din=16'hFFFF: decimal → digits 6,5,5,3,5. Then hex=1 with din held → busy for 2 cycles, digits F,F,F,F with digit4 blank (seg=7'h7F on an=01111).
4. din=16'd7, hex=0 → digit0 shows 7 (seg=7'b1111000); digits 1–4 blank.
5. din=100, then din=200 on the 5th busy cycle → disp_val=100 after the first conversion. One IDLE cycle later busy reasserts, and disp_val=200 after a second full latency.
6. Start conversion of 999, pulse rst_n low on the 8th busy cycle → the cycle after reset release shows "0", disp_val=0. Conversion then restarts and ends with disp_val=999.
